progress_monitor: RTL and testbench
===================================

PROGRESS_MONITOR -- requirements
Module: progress_monitor

Interface
REQ-001 SHALL have parameter CODE_W, default 2: width of the progress code sampled from user GPIO pins.
REQ-002 SHALL have parameter NUM_STAGES, default 3: number of checkpoints; constraint 1 <= NUM_STAGES <= 2^CODE_W-1.
REQ-003 SHALL have parameter TIMEOUT, default 1000000: maximum clocks allowed per stage; constraint TIMEOUT >= 2.
REQ-004 SHALL have port: clock  input  1  single clock for all logic.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start_i  input  1  arm the monitor (single-cycle pulse).
REQ-007 SHALL have port: code_i  input  CODE_W  progress code from pads; asynchronous to clock.
REQ-008 SHALL have port: stage_o  output  clog2(NUM_STAGES+1)  number of checkpoints reached.
REQ-009 SHALL have port: busy_o  output  1  monitor running.
REQ-010 SHALL have port: done_o  output  1  terminal state reached (pass or fail).
REQ-011 SHALL have port: pass_o  output  1  all stages reached in order.
REQ-012 SHALL have port: fail_o  output  2  2'b01 timeout, 2'b10 order violation, 2'b00 none.
REQ-013 SHALL have port: cycles_o  output  32  clocks since start, saturating at 32'hFFFFFFFF.

Function
REQ-014 SHALL pass code_i through a two-flop synchroniser, then a third register; the filtered code is valid only when synchroniser output equals the third register.
REQ-015 SHALL register a stage advance on the 4th rising edge after code_i settles; codes held for fewer than 2 consecutive synchronised cycles SHALL be ignored.
REQ-016 SHALL implement states IDLE, RUN, PASS, FAIL; IDLE->RUN on start_i; RUN->PASS on final stage; RUN->FAIL on timeout or order error; PASS/FAIL->RUN on start_i.
REQ-017 SHALL, on entry to RUN, clear stage_o, fail_o, stage timer and cycles_o.
REQ-018 SHALL expect code value k+1 while stage_o == k; a valid filtered code equal to that value increments stage_o and clears the stage timer.
REQ-019 SHALL enter PASS when stage_o increments to NUM_STAGES; pass_o=1, done_o=1, busy_o=0.
REQ-020 SHALL enter FAIL with fail_o=2'b01 when the stage timer reaches TIMEOUT-1 in RUN without an advance.
REQ-021 SHALL give a stage advance priority over timeout when both occur on the same edge.
REQ-022 SHALL ignore start_i while in RUN.
REQ-023 SHALL increment cycles_o every clock in RUN only; cycles_o, stage_o, fail_o SHALL hold in PASS/FAIL until the next start_i.
REQ-024 SHALL treat filtered code 0 and the code equal to stage_o (last reached) as neutral in RUN.

Reset
REQ-025 SHALL, on reset assertion, immediately force state IDLE, synchroniser registers to 0, stage_o=0, busy_o=0, done_o=0, pass_o=0, fail_o=2'b00, cycles_o=0, stage timer=0.
REQ-026 SHALL abandon any in-progress run on reset mid-operation; no terminal status is reported.

Configuration
REQ-027 SHALL use macro PROGRESS_MONITOR_ORDER_CHECK_EN: when defined, a valid non-neutral code other than the expected one in RUN enters FAIL with fail_o=2'b10 on the same edge an advance would; when undefined, such codes are ignored and fail_o=2'b10 is never produced.

Verification (bench: CODE_W=2, NUM_STAGES=3, TIMEOUT=16)
REQ-028 SHALL cover: start_i, code_i 1,2,3 each held 5 clocks -> stage_o 1,2,3, each on 4th edge after change, pass_o=1, done_o=1, fail_o=0.
REQ-029 SHALL cover: start_i, code_i held 0 -> fail_o=2'b01, stage_o=0, done_o=1 after 16 RUN clocks; cycles_o frozen at 16.
REQ-030 SHALL cover: code_i 1 for one clock only then 0 -> no advance, stage_o stays 0.
REQ-031 SHALL cover: with PROGRESS_MONITOR_ORDER_CHECK_EN, code_i 1 then 3 -> fail_o=2'b10, stage_o=1; without macro same stimulus -> stays RUN, then times out with fail_o=2'b01.
REQ-032 SHALL cover: expected code becoming valid on the edge timer hits 15 -> advance, no FAIL.
REQ-033 SHALL cover: reset pulsed at stage_o=2 -> all outputs 0 without waiting for a clock edge; subsequent start_i runs a clean pass.

Source files
------------

// File: rtl/progress_monitor.sv
// Checkpoint monitor: watches a slow GPIO progress code and reports pass, timeout or
// out-of-order failure. Define PROGRESS_MONITOR_ORDER_CHECK_EN to fail on unexpected codes.
module progress_monitor #(
  parameter int CODE_W     = 2,
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start_i,
  input  logic [CODE_W-1:0]                 code_i,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic [1:0]                        fail_o,
  output logic [31:0]                       cycles_o
);

  localparam int STAGE_W = $clog2(NUM_STAGES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
  localparam logic [1:0] FAIL_ORDER   = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   sync_p0, sync_p1, code_p2;
  logic                code_vld_p2;
  logic [CODE_W-1:0]   exp_code;
  logic [STAGE_W-1:0]  stage_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [31:0]         cycles_q;
  logic [1:0]          fail_q;
  logic                is_run, advance, order_err, timeout, rearm;

  // Stage p0/p1: metastability synchroniser; p2: stability filter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      code_p2 <= '0;
    end else begin
      sync_p0 <= code_i;
      sync_p1 <= sync_p0;
      code_p2 <= sync_p1;
    end
  end

  // A code is trusted only once it has been seen on two consecutive synchronised cycles
  assign code_vld_p2 = (sync_p1 == code_p2);
  assign exp_code    = CODE_W'(stage_q) + CODE_W'(1);
  assign is_run      = (state_q == RUN);
  assign advance     = is_run && code_vld_p2 && (code_p2 == exp_code);
  assign timeout     = is_run && (timer_q == TIMER_LAST) && !advance;
  assign rearm       = start_i && !is_run;

`ifdef PROGRESS_MONITOR_ORDER_CHECK_EN
  logic neutral;
  assign neutral   = (code_p2 == '0) || (code_p2 == CODE_W'(stage_q));
  assign order_err = is_run && code_vld_p2 && !neutral && (code_p2 != exp_code);
`else
  assign order_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (advance && (stage_q == STAGE_LAST)) state_d = PASS;
        else if (order_err || timeout)          state_d = FAIL;
      end
      PASS, FAIL: if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping: advance wins over timeout on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q  <= '0;
      timer_q  <= '0;
      cycles_q <= '0;
      fail_q   <= FAIL_NONE;
    end else if (rearm) begin
      stage_q  <= '0;
      timer_q  <= '0;
      cycles_q <= '0;
      fail_q   <= FAIL_NONE;
    end else if (is_run) begin
      cycles_q <= sat_inc32(cycles_q);
      if (advance) begin
        stage_q <= stage_q + STAGE_W'(1);
        timer_q <= '0;
      end else if (order_err) begin
        fail_q  <= FAIL_ORDER;
      end else if (timeout) begin
        fail_q  <= FAIL_TIMEOUT;
      end else begin
        timer_q <= timer_q + TIMER_W'(1);
      end
    end
  end

  assign stage_o  = stage_q;
  assign busy_o   = is_run;
  assign done_o   = (state_q == PASS) || (state_q == FAIL);
  assign pass_o   = (state_q == PASS);
  assign fail_o   = fail_q;
  assign cycles_o = cycles_q;

endmodule

// File: tb/tb_progress_monitor.sv
// Directed bench for progress_monitor (CODE_W=2, NUM_STAGES=3, TIMEOUT=16).
module tb_progress_monitor;

  localparam int CODE_W     = 2;
  localparam int NUM_STAGES = 3;
  localparam int TIMEOUT    = 16;
  localparam int SW         = $clog2(NUM_STAGES + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start_i = 1'b0;
  logic [CODE_W-1:0] code_i = '0;
  logic [SW-1:0]     stage_o;
  logic              busy_o, done_o, pass_o;
  logic [1:0]        fail_o;
  logic [31:0]       cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  progress_monitor #(.CODE_W(CODE_W), .NUM_STAGES(NUM_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .code_i(code_i),
    .stage_o(stage_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .fail_o(fail_o), .cycles_o(cycles_o)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full pass: each code held 5 clocks, stage moves on the 4th edge after the change
  task automatic run_pass(input string tag);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk({tag, "_busy0"}, 32'(busy_o), 32'd1);
    chk({tag, "_stage0"}, 32'(stage_o), 32'd0);
    chk({tag, "_cyc0"}, cycles_o, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      code_i = 2'(k);
      step(3);
      chk($sformatf("%s_pre%0d", tag, k), 32'(stage_o), 32'(k - 1));
      step(1);
      chk($sformatf("%s_adv%0d", tag, k), 32'(stage_o), 32'(k));
      step(1);
    end
    chk({tag, "_pass"}, 32'(pass_o), 32'd1);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_fail"}, 32'(fail_o), 32'd0);
    chk({tag, "_cyc"}, cycles_o, 32'd14);
    code_i = '0;
    step(4);
    chk({tag, "_cyc_hold"}, cycles_o, 32'd14);
    chk({tag, "_pass_hold"}, 32'(pass_o), 32'd1);
  endtask

  initial begin
    // Reset state, observed before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst_stage", 32'(stage_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_fail", 32'(fail_o), 32'd0);
    chk("rst_cyc", cycles_o, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    chk("idle_busy", 32'(busy_o), 32'd0);

    run_pass("pass");

    // Timeout with code held at 0
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("to_clear_stage", 32'(stage_o), 32'd0);
    chk("to_clear_pass", 32'(pass_o), 32'd0);
    chk("to_clear_cyc", cycles_o, 32'd0);
    step(15);
    chk("to_busy15", 32'(busy_o), 32'd1);
    chk("to_fail15", 32'(fail_o), 32'd0);
    step(1);
    chk("to_fail", 32'(fail_o), 32'd1);
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_stage", 32'(stage_o), 32'd0);
    chk("to_cyc", cycles_o, 32'd16);
    step(3);
    chk("to_cyc_hold", cycles_o, 32'd16);

    // Single-clock glitch is filtered out
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    code_i = 2'd1;
    step(1);
    code_i = 2'd0;
    step(6);
    chk("gl_stage", 32'(stage_o), 32'd0);
    chk("gl_busy", 32'(busy_o), 32'd1);
    step(9);
    chk("gl_timeout", 32'(fail_o), 32'd1);

    // Code 1 then 3
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    code_i = 2'd1;
    step(4);
    chk("ord_stage1", 32'(stage_o), 32'd1);
    code_i = 2'd3;
    step(4);
`ifdef PROGRESS_MONITOR_ORDER_CHECK_EN
    chk("ord_fail", 32'(fail_o), 32'd2);
    chk("ord_stage", 32'(stage_o), 32'd1);
    chk("ord_done", 32'(done_o), 32'd1);
`else
    chk("ord_busy", 32'(busy_o), 32'd1);
    chk("ord_nofail", 32'(fail_o), 32'd0);
    step(11);
    chk("ord_busy19", 32'(busy_o), 32'd1);
    step(1);
    chk("ord_timeout", 32'(fail_o), 32'd1);
    chk("ord_to_stage", 32'(stage_o), 32'd1);
`endif

    // Advance lands on the same edge as the timeout would
    code_i = 2'd0;
    step(4);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(12);
    code_i = 2'd1;
    step(3);
    chk("race_pre_stage", 32'(stage_o), 32'd0);
    step(1);
    chk("race_stage", 32'(stage_o), 32'd1);
    chk("race_busy", 32'(busy_o), 32'd1);
    chk("race_fail", 32'(fail_o), 32'd0);
    chk("race_cyc", cycles_o, 32'd16);

    // Reset mid-run at stage 2, checked between clock edges
    code_i = 2'd2;
    step(4);
    chk("mid_stage2", 32'(stage_o), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_stage", 32'(stage_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_pass", 32'(pass_o), 32'd0);
    chk("mid_rst_fail", 32'(fail_o), 32'd0);
    chk("mid_rst_cyc", cycles_o, 32'd0);
    code_i = 2'd0;
    step(2);
    reset = 1'b0;
    step(2);
    chk("post_rst_idle", 32'(busy_o), 32'd0);

    run_pass("pass2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
